hazard_controller: RTL

//  Pipeline hazard/forwarding controller for the 5-stage MIPS core (F/D/E/M/W).

---
 rtl/hazard_pkg.sv | 39 +++
 rtl/hazard_controller_if.sv | 42 ++++
 rtl/hazard_controller_chk.sv | 17 +
 rtl/hazard_fwd_match.sv | 28 ++
 rtl/hazard_controller.sv | 132 +++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Package: hazard_pkg
// Shared types, default widths and the scoreboard match helper for the
// hazard/forwarding controller.
package hazard_pkg;

  localparam int DEF_REG_AW = 5;
  localparam int DEF_CNT_W  = 32;

  // E-stage operand select encoding
  typedef enum logic [1:0] {
    FWD_REG  = 2'b00,
    FWD_ALUM = 2'b01,
    FWD_ALUW = 2'b10,
    FWD_MEMW = 2'b11
  } fwd_sel_t;

  // One in-flight instruction as seen by the scoreboard
  typedef struct packed {
    logic                  valid;
    logic                  regwrite;
    logic                  load;
    logic [DEF_REG_AW-1:0] dst;
  } sb_rec_t;

  typedef enum logic {
    RUN     = 1'b0,
    LDSTALL = 1'b1
  } hz_state_t;

  localparam sb_rec_t SB_BUBBLE = '{valid: 1'b0, regwrite: 1'b0, load: 1'b0,
                                    dst: {DEF_REG_AW{1'b0}}};

  // A record produces 'src' if it is a live register write to a non-zero index
  function automatic logic rec_hits(input sb_rec_t rec, input logic [DEF_REG_AW-1:0] src);
    return rec.valid && rec.regwrite && (rec.dst == src) &&
           (src != {DEF_REG_AW{1'b0}});
  endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Interface: hazard_controller_if
// Decode-side request signals and the controller's stall/flush/forward
// responses. The decode stage uses 'master', the controller uses 'slave'.
interface hazard_controller_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);

  logic              valid_d;
  logic [REG_AW-1:0] rs_d;
  logic [REG_AW-1:0] rt_d;
  logic              use_rs_d;
  logic              use_rt_d;
  logic [REG_AW-1:0] write_reg_d;
  logic              reg_write_d;
  logic              mem_to_reg_d;
  logic              branch_taken_e;

  hazard_pkg::fwd_sel_t fwd_a_e;
  hazard_pkg::fwd_sel_t fwd_b_e;
  logic              stall_f;
  logic              stall_d;
  logic              flush_d;
  logic              flush_e;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output valid_d, rs_d, rt_d, use_rs_d, use_rt_d, write_reg_d,
           reg_write_d, mem_to_reg_d, branch_taken_e,
    input  fwd_a_e, fwd_b_e, stall_f, stall_d, flush_d, flush_e,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  valid_d, rs_d, rt_d, use_rs_d, use_rt_d, write_reg_d,
           reg_write_d, mem_to_reg_d, branch_taken_e,
    output fwd_a_e, fwd_b_e, stall_f, stall_d, flush_d, flush_e,
           stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_controller_chk.sv
// Module: hazard_controller_chk
// Protocol check: once a load-use stall has pushed a bubble into E, the
// following cycle can never raise another load-use request.
module hazard_controller_chk
  import hazard_pkg::*;
(
  input logic      clk,
  input logic      rst,
  input hz_state_t state,
  input logic      stall_req
);

  a_no_stall_in_ldstall : assert property (
    @(posedge clk) disable iff (rst) !((state == LDSTALL) && stall_req)
  );

endmodule

// File: rtl/hazard_fwd_match.sv
// Module: hazard_fwd_match
// Picks the E-stage operand source for one D-stage register read by looking
// at the instructions that will sit in M (recE now) and W (recM now).
module hazard_fwd_match
  import hazard_pkg::*;
(
  input  logic [DEF_REG_AW-1:0] src,
  input  logic                  use_src,
  input  sb_rec_t               rec_e,
  input  sb_rec_t               rec_m,
  output fwd_sel_t              sel
);

  // Nearest producer wins; a load in E is resolved by the stall, not here
  always_comb begin
    sel = FWD_REG;
    if (!use_src) begin
      sel = FWD_REG;
    end else if (rec_hits(rec_e, src)) begin
      sel = rec_e.load ? FWD_REG : FWD_ALUM;
    end else if (rec_hits(rec_m, src)) begin
      sel = rec_m.load ? FWD_MEMW : FWD_ALUW;
    end else begin
      sel = FWD_REG;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Module: hazard_controller
// Load-use stall, branch flush and E-stage forwarding control for a 5-stage
// pipeline. Optional perf counters are built only with HAZARD_PERF_CNT_EN.
// W-stage producers need no tracking: the register file is write-first, so
// the scoreboard keeps only the records that will be in M and W next cycle.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW,
  parameter int CNT_W  = DEF_CNT_W
) (
  input logic               clk,
  input logic               rst,
  hazard_controller_if.slave hz
);

  sb_rec_t   rec_d;
  sb_rec_t   rec_e;
  sb_rec_t   rec_m;
  hz_state_t state;
  hz_state_t state_next;
  fwd_sel_t  sel_a;
  fwd_sel_t  sel_b;
  logic      stall_req;
  logic      stall;
  logic      bubble;

  assign rec_d = '{valid: hz.valid_d, regwrite: hz.reg_write_d,
                   load: hz.mem_to_reg_d, dst: hz.write_reg_d};

  assign stall_req = hz.valid_d && rec_e.valid && rec_e.regwrite && rec_e.load &&
                     (rec_e.dst != {REG_AW{1'b0}}) &&
                     ((hz.use_rs_d && (hz.rs_d == rec_e.dst)) ||
                      (hz.use_rt_d && (hz.rt_d == rec_e.dst)));

  // A taken branch kills both the stall and the D instruction
  assign stall        = stall_req && !hz.branch_taken_e;
  assign bubble       = stall || hz.branch_taken_e;
  assign hz.stall_f   = stall;
  assign hz.stall_d   = stall;
  assign hz.flush_d   = hz.branch_taken_e;
  assign hz.flush_e   = hz.branch_taken_e;

  hazard_fwd_match u_match_rs (
    .src(hz.rs_d), .use_src(hz.use_rs_d), .rec_e(rec_e), .rec_m(rec_m), .sel(sel_a)
  );

  hazard_fwd_match u_match_rt (
    .src(hz.rt_d), .use_src(hz.use_rt_d), .rec_e(rec_e), .rec_m(rec_m), .sel(sel_b)
  );

  // Advance the scoreboard and register the forward selects on the D->E edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rec_e      <= SB_BUBBLE;
      rec_m      <= SB_BUBBLE;
      hz.fwd_a_e <= FWD_REG;
      hz.fwd_b_e <= FWD_REG;
    end else begin
      rec_m <= rec_e;
      if (bubble) begin
        rec_e      <= SB_BUBBLE;
        hz.fwd_a_e <= FWD_REG;
        hz.fwd_b_e <= FWD_REG;
      end else begin
        rec_e      <= rec_d;
        hz.fwd_a_e <= sel_a;
        hz.fwd_b_e <= sel_b;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state: a stall lasts exactly one cycle
  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (stall) begin
          state_next = LDSTALL;
        end else begin
          state_next = RUN;
        end
      end
      LDSTALL: state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  hazard_controller_chk u_chk (
    .clk(clk), .rst(rst), .state(state), .stall_req(stall_req)
  );

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Saturating counts of stall cycles and E flush cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= {CNT_W{1'b0}};
      flush_cnt <= {CNT_W{1'b0}};
    end else begin
      if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt <= stall_cnt;
      end
      if (hz.branch_taken_e && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        flush_cnt <= flush_cnt;
      end
    end
  end

  assign hz.stall_cnt = stall_cnt;
  assign hz.flush_cnt = flush_cnt;
`else
  assign hz.stall_cnt = {CNT_W{1'b0}};
  assign hz.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule
